clb_config_loader: RTL



---
 rtl/clb_cfg_pkg.sv | 40 ++++
 rtl/clb_config_loader.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration loader: frame layout, FSM states
// and the helper that places payload bytes into the CLB frame fields.
package clb_cfg_pkg;

   localparam int CLB_BITS_W  = 23;
   localparam int OUT_SEL_LSB = 19;
   localparam int MUX_BIT     = 18;
   localparam int FFEN_LSB    = 16;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_COUNT,
      ST_INDEX,
      ST_PAY2,
      ST_PAY1,
      ST_PAY0,
      ST_WRITE,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } loader_state_t;

   // P2[7] is not part of the frame; callers pass only P2[6:0].
   function automatic logic [CLB_BITS_W-1:0] pack_frame(
      input logic [6:0] p2_lo,
      input logic [7:0] p1,
      input logic [7:0] p0
   );
      logic [CLB_BITS_W-1:0] f;
      f                              = '0;
      f[CLB_BITS_W-1:OUT_SEL_LSB]    = p2_lo[6:3];
      f[MUX_BIT]                     = p2_lo[2];
      f[MUX_BIT-1:FFEN_LSB]          = p2_lo[1:0];
      f[FFEN_LSB-1:0]                = {p1, p0};
      return f;
   endfunction

endpackage

// File: rtl/clb_config_loader.sv
// Byte-stream bitstream loader: decodes SYNC/COUNT/frames/CHK and issues one
// registered wr_en strobe per frame to the addressed CLB.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | waiting for SYNC, other bytes discarded
// COUNT    | capture frame count N
// INDEX    | capture target CLB index
// PAY2     | capture P2 (frame bits 22:16), P2[7] flags an error
// PAY1     | capture P1 (frame bits 15:8)
// PAY0     | capture P0, register strobe and frame
// WRITE    | strobe valid this cycle, in_ready low, count down
// CHECK    | compare checksum byte against running XOR
// DONE     | good load, done held until next SYNC
// ERROR    | bad load, err held until next SYNC
module clb_config_loader
   import clb_cfg_pkg::*;
#(
   parameter int         NUM_CLB   = 16,
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         IDX_W     = $clog2(NUM_CLB)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [NUM_CLB-1:0]    wr_en,
   output logic [CLB_BITS_W-1:0] bits,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   loader_state_t         state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            chk_q, chk_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic                  idx_ok_q, idx_ok_d;
   logic [6:0]            p2_q, p2_d;
   logic [7:0]            p1_q, p1_d;
   logic [CLB_BITS_W-1:0] bits_q, bits_d;
   logic [NUM_CLB-1:0]    wr_en_q, wr_en_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic                  accept;

   assign in_ready = (state_q != ST_WRITE);
   assign accept   = in_valid && in_ready;
   assign busy     = !(state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERROR);
   assign wr_en    = wr_en_q;
   assign bits     = bits_q;
   assign done     = done_q;
   assign err      = err_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      chk_d    = chk_q;
      idx_d    = idx_q;
      idx_ok_d = idx_ok_q;
      p2_d     = p2_q;
      p1_d     = p1_q;
      bits_d   = bits_q;
      wr_en_d  = '0;
      done_d   = done_q;
      err_d    = err_q;

      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (accept && in_data == SYNC_BYTE) begin
               done_d  = 1'b0;
               err_d   = 1'b0;
               chk_d   = '0;
               state_d = ST_COUNT;
            end
         end
         ST_COUNT: begin
            if (accept) begin
               cnt_d   = in_data;
               chk_d   = chk_q ^ in_data;
               state_d = (in_data == 8'd0) ? ST_CHECK : ST_INDEX;
            end
         end
         ST_INDEX: begin
            if (accept) begin
               idx_d    = in_data[IDX_W-1:0];
               idx_ok_d = ({1'b0, in_data} < 9'(NUM_CLB));
               if (!idx_ok_d)
                  err_d = 1'b1;
               chk_d    = chk_q ^ in_data;
               state_d  = ST_PAY2;
            end
         end
         ST_PAY2: begin
            if (accept) begin
               p2_d    = in_data[6:0];
               if (in_data[7])
                  err_d = 1'b1;
               chk_d   = chk_q ^ in_data;
               state_d = ST_PAY1;
            end
         end
         ST_PAY1: begin
            if (accept) begin
               p1_d    = in_data;
               chk_d   = chk_q ^ in_data;
               state_d = ST_PAY0;
            end
         end
         ST_PAY0: begin
            if (accept) begin
               chk_d   = chk_q ^ in_data;
               bits_d  = pack_frame(p2_q, p1_q, in_data);
               // Out-of-range frames are counted but never strobed.
               if (idx_ok_q)
                  wr_en_d[idx_q] = 1'b1;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            cnt_d   = cnt_q - 8'd1;
            state_d = (cnt_q == 8'd1) ? ST_CHECK : ST_INDEX;
         end
         ST_CHECK: begin
            if (accept) begin
               if (in_data == chk_q && !err_q) begin
                  done_d  = 1'b1;
                  state_d = ST_DONE;
               end else begin
                  err_d   = 1'b1;
                  state_d = ST_ERROR;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         chk_q    <= '0;
         idx_q    <= '0;
         idx_ok_q <= 1'b0;
         p2_q     <= '0;
         p1_q     <= '0;
         bits_q   <= '0;
         wr_en_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         chk_q    <= chk_d;
         idx_q    <= idx_d;
         idx_ok_q <= idx_ok_d;
         p2_q     <= p2_d;
         p1_q     <= p1_d;
         bits_q   <= bits_d;
         wr_en_q  <= wr_en_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

endmodule
